// File: rtl/sd_dat_tx_fifo_pkg.sv
// sd_dat_tx_fifo_pkg: shared DAT path widths and FIFO level defaults
package sd_dat_tx_fifo_pkg;
    localparam int DAT_WORD_W      = 32;
    localparam int DAT_FIFO_AW     = 4;
    localparam int DAT_FIFO_AF     = 12;
    localparam int DAT_FIFO_AE     = 2;
    localparam int DAT_BLOCK_WORDS = 128;
endpackage

// File: rtl/sd_fifo_ram.sv
// sd_fifo_ram: dual-port word array, synchronous write, registered synchronous read
//  sd_clock  clock
//  clr       synchronous clear of the read register only (array keeps stale data)
//  we/waddr/wdata  write port
//  re/raddr/rdata  read port; rdata holds when re=0
module sd_fifo_ram
    import sd_dat_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DAT_WORD_W,
    parameter int ADDR_WIDTH = DAT_FIFO_AW
) (
    input  logic                  sd_clock,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge sd_clock) begin
        if (we) mem[waddr] <= wdata;
    end
    // read-before-write: a pop and push to the same slot while full returns the old word
    always_ff @(posedge sd_clock) begin
        if (clr) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sd_dat_tx_fifo.sv
// sd_dat_tx_fifo: single-clock word FIFO feeding dat_phys during card writes
//  sd_clock, reset (sync, active-low), flush (sync clear)
//  wr_en/wr_data  host push;  rd_en/rd_data  dat_phys pop (1-cycle latency)
//  count, full, empty, almost_full, almost_empty  level flags from registered count
//  overflow/underflow  sticky error flags, cleared by reset or flush
module sd_dat_tx_fifo
    import sd_dat_tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DAT_WORD_W,
    parameter int ADDR_WIDTH = DAT_FIFO_AW,
    parameter int AF_LEVEL   = DAT_FIFO_AF,
    parameter int AE_LEVEL   = DAT_FIFO_AE
) (
    input  logic                  sd_clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic clr, push, pop;
    assign clr          = ~reset | flush;
    assign full         = count == DEPTH;
    assign empty        = count == '0;
    assign almost_full  = count >= (ADDR_WIDTH+1)'(AF_LEVEL);
    assign almost_empty = count <= (ADDR_WIDTH+1)'(AE_LEVEL);
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign push = wr_en & (~full | rd_en);
    assign pop  = rd_en & ~empty;
    sd_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .sd_clock (sd_clock),
        .clr      (clr),
        .we       (push & ~clr),
        .waddr    (wr_ptr),
        .wdata    (wr_data),
        .re       (pop & ~clr),
        .raddr    (rd_ptr),
        .rdata    (rd_data)
    );
    always_ff @(posedge sd_clock) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count     <= (push & ~pop) ? count + ONE : (pop & ~push) ? count - ONE : count;
            overflow  <= overflow | (wr_en & full & ~rd_en);
            underflow <= underflow | (rd_en & empty);
        end
    end
endmodule
